muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit beside the EX-stage ALU. Takes the same x/y

---
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Operand/result bundle between the EX stage and the iterative mul/div unit.
interface muldiv_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, x, y, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, x, y, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers; one bit per cycle, WIDTH+1 cycles.
// Define MULDIV_SIGNED_EN to build signed MULT/DIV (op[0]); otherwise every op is unsigned.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH);

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic               r_done;
   logic               r_div;
   logic               r_dz;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_sh;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_q_fix;
   logic [WIDTH-1:0]   w_r_fix;
   logic [WIDTH-1:0]   w_xm;
   logic [WIDTH-1:0]   w_ym;
   logic [WIDTH-1:0]   w_hi_fin;
   logic [WIDTH-1:0]   w_lo_fin;

   // r_rem/r_q double as {upper,lower} product for mul and {remainder,quotient} for div
   assign w_sum  = {1'b0, r_rem} + ({1'b0, r_a} & {(WIDTH+1){r_q[0]}});
   assign w_sh   = {r_rem, r_q[WIDTH-1]};
   assign w_diff = w_sh - {1'b0, r_a};
   assign w_prod = {r_rem, r_q};

`ifdef MULDIV_SIGNED_EN
   logic w_sx;
   logic w_sy;
   logic r_neg_q;
   logic r_neg_r;

   assign w_sx       = bus.op[0] & bus.x[WIDTH-1];
   assign w_sy       = bus.op[0] & bus.y[WIDTH-1];
   assign w_xm       = w_sx ? -bus.x : bus.x;
   assign w_ym       = w_sy ? -bus.y : bus.y;
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_q_fix    = r_neg_q ? -r_q : r_q;
   assign w_r_fix    = r_neg_r ? -r_rem : r_rem;
`else
   logic w_unused_op0;

   assign w_unused_op0 = bus.op[0];
   assign w_xm         = bus.x;
   assign w_ym         = bus.y;
   assign w_prod_fix   = w_prod;
   assign w_q_fix      = r_q;
   assign w_r_fix      = r_rem;
`endif

   // Divide by zero: magnitude path already leaves the dividend in the remainder
   assign w_hi_fin = r_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
   assign w_lo_fin = r_div ? (r_dz ? '1 : w_q_fix) : w_prod_fix[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_div   <= 1'b0;
         r_dz    <= 1'b0;
         r_a     <= '0;
         r_rem   <= '0;
         r_q     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
`ifdef MULDIV_SIGNED_EN
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_state <= S_CALC;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_rem   <= '0;
                  r_div   <= bus.op[1];
                  r_dz    <= bus.op[1] & (bus.y == '0);
                  r_a     <= bus.op[1] ? w_ym : w_xm;
                  r_q     <= bus.op[1] ? w_xm : w_ym;
`ifdef MULDIV_SIGNED_EN
                  r_neg_q <= w_sx ^ w_sy;
                  r_neg_r <= w_sx;
`endif
               end else begin
                  if (bus.hi_we) r_hi <= bus.wdata;
                  if (bus.lo_we) r_lo <= bus.wdata;
               end
            end
            S_CALC: begin
               if (r_cnt == LAST) begin
                  r_hi    <= w_hi_fin;
                  r_lo    <= w_lo_fin;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (!r_div) begin
                     {r_rem, r_q} <= {w_sum, r_q[WIDTH-1:1]};
                  end else if (!w_diff[WIDTH]) begin
                     r_rem <= w_diff[WIDTH-1:0];
                     r_q   <= {r_q[WIDTH-2:0], 1'b1};
                  end else begin
                     r_rem <= w_sh[WIDTH-1:0];
                     r_q   <= {r_q[WIDTH-2:0], 1'b0};
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reset, mul/div results, latency, busy behaviour, MTHI/MTLO.
module tb_muldiv_unit;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   muldiv_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for done (bounded), report cycles since the start edge, then step into IDLE.
   task automatic wait_done(output int lat);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      if (lat >= 100) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got no done after %0d cycles, want done", lat);
      end
      tick();
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
      bus.start = 1'b1;
      bus.op    = op;
      bus.x     = x;
      bus.y     = y;
      tick();
      bus.start = 1'b0;
      wait_done(lat);
   endtask

   task automatic test_reset();
      int lat;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL rst_hi: got %h want 0", bus.hi); end
      n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL rst_lo: got %h want 0", bus.lo); end
      // load HI/LO so the mid-op reset has something visible to clear
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h12345678;
      tick();
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      bus.start = 1'b1; bus.op = 2'b00; bus.x = 32'hFFFFFFFF; bus.y = 32'hFFFFFFFF;
      tick();
      bus.start = 1'b0;
      repeat (10) tick();
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midop_busy: got %b want 1", bus.busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL midrst_hi: got %h want 0", bus.hi); end
      n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL midrst_lo: got %h want 0", bus.lo); end
      run_op(2'b10, 32'd100, 32'd7, lat);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL postrst_lat: got %0d want 33", lat); end
      n_cmp++; if (bus.lo !== 32'd14) begin n_err++; $display("FAIL postrst_lo: got %h want %h", bus.lo, 32'd14); end
      n_cmp++; if (bus.hi !== 32'd2) begin n_err++; $display("FAIL postrst_hi: got %h want %h", bus.hi, 32'd2); end
   endtask

   task automatic test_multu();
      int lat;
      run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL multu_lat: got %0d want 33", lat); end
      n_cmp++; if (bus.hi !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_max_hi: got %h want fffffffe", bus.hi); end
      n_cmp++; if (bus.lo !== 32'h00000001) begin n_err++; $display("FAIL multu_max_lo: got %h want 00000001", bus.lo); end
      run_op(2'b00, 32'h12345678, 32'h00000010, lat);
      n_cmp++; if (bus.hi !== 32'h00000001) begin n_err++; $display("FAIL multu_shift_hi: got %h want 00000001", bus.hi); end
      n_cmp++; if (bus.lo !== 32'h23456780) begin n_err++; $display("FAIL multu_shift_lo: got %h want 23456780", bus.lo); end
   endtask

   task automatic test_divu();
      int lat;
      run_op(2'b10, 32'd5, 32'd0, lat);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divu_dz_lat: got %0d want 33", lat); end
      n_cmp++; if (bus.lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divu_dz_lo: got %h want ffffffff", bus.lo); end
      n_cmp++; if (bus.hi !== 32'd5) begin n_err++; $display("FAIL divu_dz_hi: got %h want 00000005", bus.hi); end
      run_op(2'b10, 32'hFFFFFFFF, 32'h10, lat);
      n_cmp++; if (bus.lo !== 32'h0FFFFFFF) begin n_err++; $display("FAIL divu_big_lo: got %h want 0fffffff", bus.lo); end
      n_cmp++; if (bus.hi !== 32'h0000000F) begin n_err++; $display("FAIL divu_big_hi: got %h want 0000000f", bus.hi); end
   endtask

   task automatic test_signed();
      int lat;
`ifdef MULDIV_SIGNED_EN
      run_op(2'b01, 32'hFFFFFFFD, 32'd5, lat);
      n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_neg_hi: got %h want ffffffff", bus.hi); end
      n_cmp++; if (bus.lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_neg_lo: got %h want fffffff1", bus.lo); end
      run_op(2'b11, 32'hFFFFFFF9, 32'd2, lat);
      n_cmp++; if (bus.lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_neg_lo: got %h want fffffffd", bus.lo); end
      n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_neg_hi: got %h want ffffffff", bus.hi); end
      run_op(2'b11, 32'd7, 32'hFFFFFFFE, lat);
      n_cmp++; if (bus.lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_negy_lo: got %h want fffffffd", bus.lo); end
      n_cmp++; if (bus.hi !== 32'd1) begin n_err++; $display("FAIL div_negy_hi: got %h want 00000001", bus.hi); end
      run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat);
      n_cmp++; if (bus.lo !== 32'h80000000) begin n_err++; $display("FAIL div_ovf_lo: got %h want 80000000", bus.lo); end
      n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi: got %h want 00000000", bus.hi); end
      run_op(2'b11, 32'hFFFFFFFB, 32'd0, lat);
      n_cmp++; if (bus.lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_dz_lo: got %h want ffffffff", bus.lo); end
      n_cmp++; if (bus.hi !== 32'hFFFFFFFB) begin n_err++; $display("FAIL div_dz_hi: got %h want fffffffb", bus.hi); end
`else
      run_op(2'b01, 32'hFFFFFFFD, 32'd5, lat);
      n_cmp++; if (bus.hi !== 32'h00000004) begin n_err++; $display("FAIL mult_uns_hi: got %h want 00000004", bus.hi); end
      n_cmp++; if (bus.lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_uns_lo: got %h want fffffff1", bus.lo); end
      run_op(2'b11, 32'hFFFFFFF9, 32'd2, lat);
      n_cmp++; if (bus.lo !== 32'h7FFFFFFC) begin n_err++; $display("FAIL div_uns_lo: got %h want 7ffffffc", bus.lo); end
      n_cmp++; if (bus.hi !== 32'd1) begin n_err++; $display("FAIL div_uns_hi: got %h want 00000001", bus.hi); end
`endif
   endtask

   task automatic test_busy_ignore();
      int pulses;
      int first;
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h11111111;
      tick();
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      bus.start = 1'b1; bus.op = 2'b00; bus.x = 32'd3; bus.y = 32'd4;
      tick();
      bus.start = 1'b0;
      pulses = 0;
      first  = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 5 || c == 20) begin
            bus.start = 1'b1; bus.op = 2'b10; bus.x = 32'd1000; bus.y = 32'd3;
         end
         if (c == 8) begin
            bus.hi_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
         end
         tick();
         bus.start = 1'b0;
         bus.hi_we = 1'b0;
         if (c == 9) begin
            n_cmp++; if (bus.hi !== 32'h11111111) begin n_err++; $display("FAIL busy_hi_we: got %h want 11111111", bus.hi); end
            n_cmp++; if (bus.lo !== 32'h11111111) begin n_err++; $display("FAIL busy_lo_stable: got %h want 11111111", bus.lo); end
         end
         if (c == 10) begin
            n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_level: got %b want 1", bus.busy); end
         end
         if (bus.done === 1'b1) begin
            pulses++;
            if (first == 0) first = c;
         end
      end
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
      n_cmp++; if (first !== 33) begin n_err++; $display("FAIL ignore_lat: got %0d want 33", first); end
      n_cmp++; if (bus.hi !== 32'd0) begin n_err++; $display("FAIL ignore_hi: got %h want 00000000", bus.hi); end
      n_cmp++; if (bus.lo !== 32'd12) begin n_err++; $display("FAIL ignore_lo: got %h want 0000000c", bus.lo); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ignore_idle: got %b want 0", bus.busy); end
   endtask

   task automatic test_mthi_mtlo();
      int lat;
      bus.hi_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
      tick();
      bus.hi_we = 1'b0;
      n_cmp++; if (bus.hi !== 32'hA5A5A5A5) begin n_err++; $display("FAIL mthi_hi: got %h want a5a5a5a5", bus.hi); end
      n_cmp++; if (bus.lo !== 32'd12) begin n_err++; $display("FAIL mthi_lo_kept: got %h want 0000000c", bus.lo); end
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5A5A5A5A;
      tick();
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      n_cmp++; if (bus.hi !== 32'h5A5A5A5A) begin n_err++; $display("FAIL both_hi: got %h want 5a5a5a5a", bus.hi); end
      n_cmp++; if (bus.lo !== 32'h5A5A5A5A) begin n_err++; $display("FAIL both_lo: got %h want 5a5a5a5a", bus.lo); end
      // write in the same cycle as an accepted start must be dropped
      bus.start = 1'b1; bus.op = 2'b00; bus.x = 32'd2; bus.y = 32'd3;
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
      tick();
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      n_cmp++; if (bus.hi !== 32'h5A5A5A5A) begin n_err++; $display("FAIL start_we_hi: got %h want 5a5a5a5a", bus.hi); end
      n_cmp++; if (bus.lo !== 32'h5A5A5A5A) begin n_err++; $display("FAIL start_we_lo: got %h want 5a5a5a5a", bus.lo); end
      wait_done(lat);
      n_cmp++; if (bus.lo !== 32'd6) begin n_err++; $display("FAIL start_we_res: got %h want 00000006", bus.lo); end
   endtask

   task automatic test_back_to_back();
      int lat;
      run_op(2'b00, 32'd7, 32'd6, lat);
      n_cmp++; if (bus.lo !== 32'd42) begin n_err++; $display("FAIL b2b_mul_lo: got %h want 0000002a", bus.lo); end
      run_op(2'b10, 32'd42, 32'd5, lat);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL b2b_lat: got %0d want 33", lat); end
      n_cmp++; if (bus.lo !== 32'd8) begin n_err++; $display("FAIL b2b_div_lo: got %h want 00000008", bus.lo); end
      n_cmp++; if (bus.hi !== 32'd2) begin n_err++; $display("FAIL b2b_div_hi: got %h want 00000002", bus.hi); end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.x     = '0;
      bus.y     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;
      test_reset();
      test_multu();
      test_divu();
      test_signed();
      test_busy_ignore();
      test_mthi_mtlo();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
